// File: rtl/two_of_three_tx.sv
// Serial transmitter for the two-hot (2-of-3) line code: each 4-bit nibble is
// split into three base-3 trits and sent MSB first behind a SYNC codeword.
module two_of_three_tx #(
    parameter int GAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [2:0] code_out,
    output logic       code_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_T2,
        S_T1,
        S_T0,
        S_GAP
    } state_t;

    localparam logic [2:0] CODE_IDLE = 3'b000;
    localparam logic [2:0] CODE_SYNC = 3'b111;
    localparam logic       HAS_GAP   = (GAP > 0);
    localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [5:0] trits_q, trits_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [2:0] code_out_q, code_out_d;
    logic       code_valid_q, code_valid_d;
    logic       busy_q, busy_d;

    logic       accept;
    logic [1:0] nib_t2, nib_t1, nib_t0;
    logic [3:0] nib_rem;
    logic [1:0] nib_sub;

    function automatic logic [2:0] trit_code(input logic [1:0] t);
        case (t)
            2'd0:    trit_code = 3'b011;
            2'd1:    trit_code = 3'b101;
            default: trit_code = 3'b110;
        endcase
    endfunction

    assign in_ready = rst_n && ((state_q == S_IDLE) || ((state_q == S_T0) && !HAS_GAP));
    assign accept   = in_valid && in_ready;

    // The remainder after removing 9 is at most 8, so t0 only needs the low two
    // bits: subtracting 6 or 3 modulo 4 yields the remainder of the division by 3.
    always_comb begin
        nib_t2  = (in_data >= 4'd9) ? 2'd1 : 2'd0;
        nib_rem = in_data - ((in_data >= 4'd9) ? 4'd9 : 4'd0);
        if (nib_rem >= 4'd6) begin
            nib_t1  = 2'd2;
            nib_sub = 2'b10;
        end else if (nib_rem >= 4'd3) begin
            nib_t1  = 2'd1;
            nib_sub = 2'b11;
        end else begin
            nib_t1  = 2'd0;
            nib_sub = 2'b00;
        end
        nib_t0 = nib_rem[1:0] - nib_sub;
    end

    always_comb begin
        state_d   = state_q;
        trits_d   = trits_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SYNC;
                    trits_d = {nib_t2, nib_t1, nib_t0};
                end
            end
            S_SYNC: state_d = S_T2;
            S_T2:   state_d = S_T1;
            S_T1:   state_d = S_T0;
            S_T0: begin
                if (HAS_GAP) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (accept) begin
                    state_d = S_SYNC;
                    trits_d = {nib_t2, nib_t1, nib_t0};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it when registered.
    always_comb begin
        code_out_d   = CODE_IDLE;
        code_valid_d = 1'b0;
        case (state_d)
            S_SYNC: begin
                code_out_d   = CODE_SYNC;
                code_valid_d = 1'b1;
            end
            S_T2: begin
                code_out_d   = trit_code(trits_d[5:4]);
                code_valid_d = 1'b1;
            end
            S_T1: begin
                code_out_d   = trit_code(trits_d[3:2]);
                code_valid_d = 1'b1;
            end
            S_T0: begin
                code_out_d   = trit_code(trits_d[1:0]);
                code_valid_d = 1'b1;
            end
            default: begin
                code_out_d   = CODE_IDLE;
                code_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            trits_q      <= 6'd0;
            gap_cnt_q    <= 4'd0;
            code_out_q   <= CODE_IDLE;
            code_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            trits_q      <= trits_d;
            gap_cnt_q    <= gap_cnt_d;
            code_out_q   <= code_out_d;
            code_valid_q <= code_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign code_out   = code_out_q;
    assign code_valid = code_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_two_of_three_tx.sv
// Directed bench for two_of_three_tx: one instance with GAP=0 and one with GAP=3.
// Outputs are sampled 1ns after each rising edge, then inputs are driven.
module tb_two_of_three_tx;

    typedef struct {
        logic [3:0]  nib;
        logic [11:0] codes;
        string       name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid0, in_ready0, code_valid0, busy0;
    logic [3:0] in_data0;
    logic [2:0] code_out0;
    logic       in_valid3, in_ready3, code_valid3, busy3;
    logic [3:0] in_data3;
    logic [2:0] code_out3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    two_of_three_tx #(.GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .code_out(code_out0), .code_valid(code_valid0), .busy(busy0)
    );

    two_of_three_tx #(.GAP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .code_out(code_out3), .code_valid(code_valid3), .busy(busy3)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%b required=%b", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] d);
        in_valid0 = v;
        in_data0  = d;
    endtask

    // Compares {code_out, code_valid, busy, in_ready} of the GAP=0 instance.
    task automatic chk0(input string name, input logic [2:0] code, input logic cv, input logic bsy, input logic rdy);
        checkOutput(name, {6'b0, code_out0, code_valid0, busy0, in_ready0}, {6'b0, code, cv, bsy, rdy});
    endtask

    task automatic chk3(input string name, input logic [2:0] code, input logic cv, input logic bsy, input logic rdy);
        checkOutput(name, {6'b0, code_out3, code_valid3, busy3, in_ready3}, {6'b0, code, cv, bsy, rdy});
    endtask

    // Sends one nibble from idle on the GAP=0 instance and checks every cycle.
    task automatic sendSingle(input string name, input logic [3:0] nib, input logic [11:0] codes);
        applyStimulus(1'b1, nib);
        step();
        chk0({name, "_sync"}, 3'b111, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, ~nib);
        step();
        chk0({name, "_t2"}, codes[11:9], 1'b1, 1'b1, 1'b0);
        step();
        chk0({name, "_t1"}, codes[8:6], 1'b1, 1'b1, 1'b0);
        step();
        chk0({name, "_t0"}, codes[5:3], 1'b1, 1'b1, 1'b1);
        step();
        chk0({name, "_idle"}, 3'b000, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic checker2of3(input logic [2:0] c);
        return (c == 3'b011) || (c == 3'b101) || (c == 3'b110);
    endfunction

    function automatic int decodeTrit(input logic [2:0] c);
        case (c)
            3'b011:  return 0;
            3'b101:  return 1;
            3'b110:  return 2;
            default: return 99;
        endcase
    endfunction

    vec_t vecs[4];

    initial begin
        // Hand-computed frames: codes = {code(t2), code(t1), code(t0), 3'b000}.
        vecs[0] = '{nib: 4'd5,  codes: {3'b011, 3'b101, 3'b110, 3'b000}, name: "nib5"};
        vecs[1] = '{nib: 4'd15, codes: {3'b101, 3'b110, 3'b011, 3'b000}, name: "nib15"};
        vecs[2] = '{nib: 4'd0,  codes: {3'b011, 3'b011, 3'b011, 3'b000}, name: "nib0"};
        vecs[3] = '{nib: 4'd13, codes: {3'b101, 3'b101, 3'b101, 3'b000}, name: "nib13"};

        // Reset held with in_valid high: no frame, everything quiet.
        rst_n     = 1'b0;
        applyStimulus(1'b1, 4'd5);
        in_valid3 = 1'b1;
        in_data3  = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk0("reset0", 3'b000, 1'b0, 1'b0, 1'b0);
            chk3("reset3", 3'b000, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 4'd0);
        in_valid3 = 1'b0;
        rst_n     = 1'b1;
        step();
        chk0("post_reset_idle", 3'b000, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            sendSingle(vecs[i].name, vecs[i].nib, vecs[i].codes);
        end

        // Back-to-back 7 then 13 with in_valid held; junk data mid-frame is ignored.
        applyStimulus(1'b1, 4'd7);
        step();
        chk0("b2b_sync7", 3'b111, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd2);
        step();
        chk0("b2b_t2_7", 3'b011, 1'b1, 1'b1, 1'b0);
        step();
        chk0("b2b_t1_7", 3'b110, 1'b1, 1'b1, 1'b0);
        step();
        chk0("b2b_t0_7", 3'b101, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'd13);
        step();
        chk0("b2b_sync13", 3'b111, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0);
        step();
        chk0("b2b_t2_13", 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        chk0("b2b_t1_13", 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        chk0("b2b_t0_13", 3'b101, 1'b1, 1'b1, 1'b1);
        step();
        chk0("b2b_idle", 3'b000, 1'b0, 1'b0, 1'b1);

        // GAP=3 with requests held: 3 idle-coded gap cycles, then an IDLE accept cycle.
        in_valid3 = 1'b1;
        in_data3  = 4'd5;
        step();
        chk3("gap_sync5", 3'b111, 1'b1, 1'b1, 1'b0);
        step();
        chk3("gap_t2_5", 3'b011, 1'b1, 1'b1, 1'b0);
        step();
        chk3("gap_t1_5", 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        chk3("gap_t0_5", 3'b110, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("gap_cycle", 3'b000, 1'b0, 1'b1, 1'b0);
        end
        step();
        chk3("gap_idle", 3'b000, 1'b0, 1'b0, 1'b1);
        in_data3 = 4'd15;
        step();
        chk3("gap_sync15", 3'b111, 1'b1, 1'b1, 1'b0);
        in_valid3 = 1'b0;
        step();
        chk3("gap_t2_15", 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        chk3("gap_t1_15", 3'b110, 1'b1, 1'b1, 1'b0);
        step();
        chk3("gap_t0_15", 3'b011, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("gap2_cycle", 3'b000, 1'b0, 1'b1, 1'b0);
        end
        step();
        chk3("gap2_idle", 3'b000, 1'b0, 1'b0, 1'b1);

        // Reset during T1 of nibble 9; t0 must never appear, then nibble 4 on release.
        applyStimulus(1'b1, 4'd9);
        step();
        chk0("rst_sync9", 3'b111, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0);
        step();
        chk0("rst_t2_9", 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        chk0("rst_t1_9", 3'b011, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        chk0("rst_abort", 3'b000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd4);
        #1;
        chk0("rst_release_ready", 3'b000, 1'b0, 1'b0, 1'b1);
        step();
        chk0("rst_sync4", 3'b111, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0);
        step();
        chk0("rst_t2_4", 3'b011, 1'b1, 1'b1, 1'b0);
        step();
        chk0("rst_t1_4", 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        chk0("rst_t0_4", 3'b101, 1'b1, 1'b1, 1'b1);
        step();
        chk0("rst_idle", 3'b000, 1'b0, 1'b0, 1'b1);

        // All 16 nibbles through a two-hot checker model and a trit decoder.
        for (int v = 0; v < 16; v++) begin
            logic [4:0] chk_bits;
            int         decoded;
            applyStimulus(1'b1, 4'(v));
            step();
            chk_bits[4] = checker2of3(code_out0) | ~code_valid0;
            applyStimulus(1'b0, 4'd0);
            decoded = 0;
            for (int t = 0; t < 3; t++) begin
                step();
                chk_bits[3 - t] = checker2of3(code_out0) & code_valid0;
                decoded = decoded * 3 + decodeTrit(code_out0);
            end
            step();
            chk_bits[0] = checker2of3(code_out0) | code_valid0;
            checkOutput($sformatf("exh_checker_%0d", v), {7'b0, chk_bits}, 12'b0000_0000_1110);
            checkOutput($sformatf("exh_decode_%0d", v), 12'(decoded), 12'(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
